// File: rtl/gold_pkg.sv
// gold_pkg: shared constants and types for the gold_cpu processor.
//   - Opcode, ALU function and lane-width (ww) encodings.
//   - FSM state enum {EXEC, LOAD}.
//   - NIC window select value on ea[16:17].
// Bit numbering is big-endian throughout (bit 0 is the MSB).
package gold_pkg;

    localparam logic [0:5] OP_ALU  = 6'b101010;
    localparam logic [0:5] OP_LD   = 6'b100000;
    localparam logic [0:5] OP_SD   = 6'b100001;
    localparam logic [0:5] OP_BEZ  = 6'b100010;
    localparam logic [0:5] OP_BNEZ = 6'b100011;
    localparam logic [0:5] OP_NOP  = 6'b111100;
    localparam logic [0:5] OP_HALT = 6'b000000;

    localparam logic [0:5] FN_AND = 6'b000001;
    localparam logic [0:5] FN_OR  = 6'b000010;
    localparam logic [0:5] FN_XOR = 6'b000011;
    localparam logic [0:5] FN_NOT = 6'b000100;
    localparam logic [0:5] FN_MOV = 6'b000101;
    localparam logic [0:5] FN_ADD = 6'b000110;
    localparam logic [0:5] FN_SUB = 6'b000111;
    localparam logic [0:5] FN_SLL = 6'b001000;
    localparam logic [0:5] FN_SRL = 6'b001001;

    localparam logic [0:1] WW_8  = 2'b00;
    localparam logic [0:1] WW_16 = 2'b01;
    localparam logic [0:1] WW_32 = 2'b10;
    localparam logic [0:1] WW_64 = 2'b11;

    localparam logic [0:1] NIC_SEL = 2'b11;

    typedef enum logic {
        EXEC = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Only the defined ALU functions produce a register writeback.
    function automatic logic func_writes(input logic [0:5] func);
        return (func >= FN_AND) && (func <= FN_SRL);
    endfunction

endpackage

// File: rtl/gold_if.sv
// gold_if: bus bundle between gold_cpu and its IMEM, DMEM and NIC.
//   master (cpu side): drives pc, DMEM request/write data, NIC request/write data;
//                      receives instruction, dataIn (DMEM) and d_out (NIC).
//   slave  (memory/NIC side): the mirror image.
interface gold_if;
    logic [0:31] pc;
    logic [0:31] instruction;
    logic [0:63] dataIn;
    logic [0:63] dataOut;
    logic [0:31] memAddr;
    logic        memEn;
    logic        memWrEn;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicEnWr;

    modport master (
        output pc, dataOut, memAddr, memEn, memWrEn, addr, d_in, nicEn, nicEnWr,
        input  instruction, dataIn, d_out
    );

    modport slave (
        input  pc, dataOut, memAddr, memEn, memWrEn, addr, d_in, nicEn, nicEnWr,
        output instruction, dataIn, d_out
    );
endinterface

// File: rtl/gold_alu.sv
// gold_alu: combinational lane-wise 64-bit ALU.
//   a, b   : operands [0:63]
//   ww     : lane width select (00=8x8, 01=4x16, 10=2x32, 11=1x64)
//   func   : operation code
//   result : lane-wise result [0:63]
//   valid  : high when func is a defined operation (writeback allowed)
module gold_alu
    import gold_pkg::*;
(
    input  logic [0:63] a,
    input  logic [0:63] b,
    input  logic [0:1]  ww,
    input  logic [0:5]  func,
    output logic [0:63] result,
    output logic        valid
);

    // Lanes are independent, so work on conventionally numbered copies;
    // the positional assignment keeps bit 0 (MSB) at bit 63.
    logic [63:0] a_le;
    logic [63:0] b_le;
    logic [3:0][63:0] lane_res;

    assign a_le = a;
    assign b_le = b;

    // One result per lane width; ww picks one at the end.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_width
            localparam int W  = 8 << gi;
            localparam int N  = 64 / W;
            localparam int SH = $clog2(W);

            logic [W-1:0] la;
            logic [W-1:0] lb;
            logic [W-1:0] lr;
            logic [63:0]  res;

            always_comb begin
                res = '0;
                la  = '0;
                lb  = '0;
                lr  = '0;
                for (int i = 0; i < N; i++) begin
                    la = a_le[i*W +: W];
                    lb = b_le[i*W +: W];
                    case (func)
                        FN_AND:  lr = la & lb;
                        FN_OR:   lr = la | lb;
                        FN_XOR:  lr = la ^ lb;
                        FN_NOT:  lr = ~la;
                        FN_MOV:  lr = la;
                        FN_ADD:  lr = la + lb;
                        FN_SUB:  lr = la - lb;
                        // Shift amount comes from the low log2(W) bits of the same lane of b.
                        FN_SLL:  lr = la << lb[SH-1:0];
                        FN_SRL:  lr = la >> lb[SH-1:0];
                        default: lr = '0;
                    endcase
                    res[i*W +: W] = lr;
                end
            end

            assign lane_res[gi] = res;
        end
    endgenerate

    always_comb begin
        case (ww)
            WW_8:    result = lane_res[0];
            WW_16:   result = lane_res[1];
            WW_32:   result = lane_res[2];
            WW_64:   result = lane_res[3];
            default: result = lane_res[3];
        endcase
    end

    assign valid = func_writes(func);

endmodule

// File: rtl/gold_cpu.sv
// gold_cpu: compact 64-bit non-pipelined processor, two-state FSM (EXEC, LOAD).
//   clk   : system clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : gold_if.master -- pc/instruction (IMEM), memAddr/memEn/memWrEn/
//           dataOut/dataIn (DMEM), addr/nicEn/nicEnWr/d_in/d_out (NIC)
// EXEC executes one instruction per cycle and drives memory/NIC requests
// combinationally; LD additionally spends one LOAD cycle to capture read data.
module gold_cpu
    import gold_pkg::*;
#(
    parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
    input logic   clk,
    input logic   reset,
    gold_if.master bus
);

    state_t      state_reg;
    state_t      state_next;
    logic [0:31] pc_reg;
    logic [0:31] pc_next;
    logic [0:31] pc_plus4;
    logic [0:63] regs [32];

    // Instruction fields
    logic [0:31] instr;
    logic [0:5]  op;
    logic [0:4]  rd;
    logic [0:4]  ra;
    logic [0:4]  rb;
    logic [0:1]  ww;
    logic [0:5]  func;
    logic [0:31] ea;
    logic        nic_sel;
    logic        unused_bits;

    logic [0:63] rd_val;
    logic [0:63] ra_val;
    logic [0:63] rb_val;
    logic [0:63] alu_result;
    logic        alu_valid;

    logic        wr_en;
    logic [0:63] wr_data;

    logic [0:31] mem_addr;
    logic        mem_en;
    logic        mem_wr_en;
    logic [0:63] data_out;
    logic [0:1]  nic_addr;
    logic        nic_en;
    logic        nic_wr_en;
    logic [0:63] nic_data;

    assign instr       = bus.instruction;
    assign op          = instr[0:5];
    assign rd          = instr[6:10];
    assign ra          = instr[11:15];
    assign rb          = instr[16:20];
    assign ww          = instr[24:25];
    assign func        = instr[26:31];
    assign ea          = {16'b0, instr[16:31]};
    assign nic_sel     = (ea[16:17] == NIC_SEL);
    assign unused_bits = ^instr[21:23];

    // r0 is hard-wired to zero on read.
    assign rd_val = (rd == 5'd0) ? '0 : regs[rd];
    assign ra_val = (ra == 5'd0) ? '0 : regs[ra];
    assign rb_val = (rb == 5'd0) ? '0 : regs[rb];

    assign pc_plus4 = pc_reg + 32'd4;

    gold_alu u_alu (
        .a      (ra_val),
        .b      (rb_val),
        .ww     (ww),
        .func   (func),
        .result (alu_result),
        .valid  (alu_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= EXEC;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Reset also clears any pending LOAD writeback, so an aborted load leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (rd != 5'd0)) begin
            regs[rd] <= wr_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        wr_en      = 1'b0;
        wr_data    = '0;
        mem_addr   = '0;
        mem_en     = 1'b0;
        mem_wr_en  = 1'b0;
        data_out   = '0;
        nic_addr   = '0;
        nic_en     = 1'b0;
        nic_wr_en  = 1'b0;
        nic_data   = '0;

        case (state_reg)
            EXEC: begin
                case (op)
                    OP_ALU: begin
                        wr_en   = alu_valid;
                        wr_data = alu_result;
                        pc_next = pc_plus4;
                    end
                    OP_LD, OP_SD: begin
                        if (nic_sel) begin
                            nic_addr  = ea[30:31];
                            nic_en    = 1'b1;
                            nic_wr_en = (op == OP_SD);
                            nic_data  = (op == OP_SD) ? rd_val : '0;
                        end else begin
                            mem_addr  = ea;
                            mem_en    = 1'b1;
                            mem_wr_en = (op == OP_SD);
                            data_out  = (op == OP_SD) ? rd_val : '0;
                        end
                        // A load keeps pc until its data is captured in LOAD.
                        if (op == OP_LD) begin
                            state_next = LOAD;
                        end else begin
                            pc_next = pc_plus4;
                        end
                    end
                    OP_BEZ:  pc_next = (rd_val == '0) ? ea : pc_plus4;
                    OP_BNEZ: pc_next = (rd_val != '0) ? ea : pc_plus4;
                    OP_HALT: pc_next = pc_reg;
                    OP_NOP:  pc_next = pc_plus4;
                    default: pc_next = pc_plus4;
                endcase
            end
            LOAD: begin
                // The LD word is still on instruction, so its decode picks the source.
                wr_en      = 1'b1;
                wr_data    = nic_sel ? bus.d_out : bus.dataIn;
                pc_next    = pc_plus4;
                state_next = EXEC;
            end
            default: state_next = EXEC;
        endcase
    end

    // Outputs are forced low for as long as reset is held.
    assign bus.pc      = reset ? '0   : pc_reg;
    assign bus.memAddr = reset ? '0   : mem_addr;
    assign bus.memEn   = reset ? 1'b0 : mem_en;
    assign bus.memWrEn = reset ? 1'b0 : mem_wr_en;
    assign bus.dataOut = reset ? '0   : data_out;
    assign bus.addr    = reset ? '0   : nic_addr;
    assign bus.nicEn   = reset ? 1'b0 : nic_en;
    assign bus.nicEnWr = reset ? 1'b0 : nic_wr_en;
    assign bus.d_in    = reset ? '0   : nic_data;

endmodule

// File: tb/tb_gold_cpu.sv
// tb_gold_cpu: self-checking bench for gold_cpu.
// Models IMEM (combinational), DMEM (synchronous) and a 4-register NIC.
// ALU vectors run as small programs (LD, LD, ALU, SD, HALT) and the stored
// result is compared with a table constant or an arithmetic reference model.
module tb_gold_cpu;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    gold_if bus ();

    gold_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory / NIC models ----------------
    logic [0:31] imem [256];
    logic [0:63] dmem [256];
    logic [0:63] nic_regs [4];
    logic [0:63] dmem_rd;
    logic [0:63] nic_rd;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [0:63] pre_data;

    assign bus.instruction = imem[bus.pc[22:29]];
    assign bus.dataIn      = dmem_rd;
    assign bus.d_out       = nic_rd;

    always @(posedge clk) begin
        if (pre_we) begin
            dmem[pre_addr] <= pre_data;
        end else if (bus.memEn) begin
            if (bus.memWrEn) dmem[bus.memAddr[24:31]] <= bus.dataOut;
            else             dmem_rd <= dmem[bus.memAddr[24:31]];
        end
        if (bus.nicEn && bus.nicEnWr) nic_regs[bus.addr] <= bus.d_in;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_alu(input logic [4:0] rd, input logic [4:0] ra,
                                            input logic [4:0] rb, input logic [1:0] ww,
                                            input logic [5:0] fn);
        return {6'b101010, rd, ra, rb, 3'b000, ww, fn};
    endfunction

    function automatic logic [31:0] enc_mem(input logic [5:0] op, input logic [4:0] rd,
                                            input logic [15:0] imm);
        return {op, rd, 5'b00000, imm};
    endfunction

    localparam logic [5:0] LD   = 6'b100000;
    localparam logic [5:0] SD   = 6'b100001;
    localparam logic [5:0] BEZ  = 6'b100010;
    localparam logic [5:0] BNEZ = 6'b100011;
    localparam logic [5:0] NOP  = 6'b111100;

    // Reference ALU: each lane treated as an unsigned integer modulo 2^w.
    function automatic logic [63:0] ref_alu(input logic [1:0] ww, input logic [5:0] fn,
                                            input logic [63:0] a, input logic [63:0] b);
        int w;
        int n;
        int s;
        logic [127:0] m;
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] r;
        logic [127:0] acc;
        w   = 8 << ww;
        n   = 64 / w;
        m   = 128'd1 << w;
        acc = '0;
        // Undefined funcs write nothing: the destination keeps its reset value 0.
        if (fn < 6'd1 || fn > 6'd9) return 64'h0;
        for (int i = 0; i < n; i++) begin
            x = ({64'd0, a} >> (i * w)) % m;
            y = ({64'd0, b} >> (i * w)) % m;
            s = int'(y % 128'(w));
            case (fn)
                6'd1:    r = x & y;
                6'd2:    r = x | y;
                6'd3:    r = x ^ y;
                6'd4:    r = m - 128'd1 - x;
                6'd5:    r = x;
                6'd6:    r = (x + y) % m;
                6'd7:    r = (x + m - y) % m;
                6'd8:    r = (x * (128'd1 << s)) % m;
                6'd9:    r = x / (128'd1 << s);
                default: r = '0;
            endcase
            acc = acc + r * (128'd1 << (i * w));
        end
        return acc[63:0];
    endfunction

    task automatic poke(input logic [7:0] a, input logic [63:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we   = 1'b0;
    endtask

    task automatic begin_prog();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic run_to_halt(input string name, input int max);
        int n;
        n = 0;
        while (bus.instruction != 32'h0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < max), 64'd1);
    endtask

    task automatic run_alu(input int idx, input logic [1:0] ww, input logic [5:0] fn,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        begin_prog();
        imem[0] = enc_mem(LD, 5'd1, 16'd1);
        imem[1] = enc_mem(LD, 5'd2, 16'd2);
        imem[2] = enc_alu(5'd3, 5'd1, 5'd2, ww, fn);
        imem[3] = enc_mem(SD, 5'd3, 16'd3);
        poke(8'd1, a);
        poke(8'd2, b);
        poke(8'd3, 64'hA5A5_A5A5_A5A5_A5A5);
        release_reset();
        run_to_halt("alu_halt", 50);
        $display("alu %0d ww=%0d fn=%0d a=%h b=%h result=%h expect=%h",
                 idx, ww, fn, a, b, dmem[3], exp);
        chk($sformatf("alu_%0d", idx), dmem[3], exp);
    endtask

    typedef struct {
        logic [1:0]  ww;
        logic [5:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [15];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] pc_hold;
        logic [1:0]  rww;
        logic [5:0]  rfn;
        logic [63:0] ra;
        logic [63:0] rb;

        checks  = 0;
        errors  = 0;
        pre_we  = 1'b0;
        nic_rd  = 64'h55;
        dmem_rd = '0;

        vecs[0]  = '{2'b00, 6'd6, 64'h01FF_0001_7FFF_FFFF, 64'h0101_0001_0001_0001, 64'h0200_0002_7F00_FF00};
        vecs[1]  = '{2'b11, 6'd6, 64'h01FF_0001_7FFF_FFFF, 64'h0101_0001_0001_0001, 64'h0300_0002_8001_0000};
        vecs[2]  = '{2'b10, 6'd6, 64'h01FF_0001_7FFF_FFFF, 64'h0101_0001_0001_0001, 64'h0300_0002_8001_0000};
        vecs[3]  = '{2'b01, 6'd6, 64'h01FF_0001_7FFF_FFFF, 64'h0101_0001_0001_0001, 64'h0300_0002_8000_0000};
        vecs[4]  = '{2'b00, 6'd7, 64'h0000_0000_0000_0000, 64'h0101_0101_0101_0101, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{2'b00, 6'd8, 64'h0101_0101_0101_0101, 64'h0001_0203_0405_0607, 64'h0102_0408_1020_4080};
        vecs[6]  = '{2'b01, 6'd9, 64'h8000_8000_8000_8000, 64'h0000_0001_000F_0013, 64'h8000_4000_0001_1000};
        vecs[7]  = '{2'b11, 6'd8, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0043, 64'h0000_0000_0000_0008};
        vecs[8]  = '{2'b11, 6'd1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000};
        vecs[9]  = '{2'b10, 6'd3, 64'hFFFF_0000_1234_5678, 64'h0F0F_0F0F_0000_FFFF, 64'hF0F0_0F0F_1234_A987};
        vecs[10] = '{2'b00, 6'd4, 64'h00FF_1234_0000_FFFF, 64'h0,                   64'hFF00_EDCB_FFFF_0000};
        vecs[11] = '{2'b11, 6'd5, 64'hDEAD_BEEF_0BAD_F00D, 64'h1234,                64'hDEAD_BEEF_0BAD_F00D};
        vecs[12] = '{2'b01, 6'd2, 64'h1200_0034_0000_0000, 64'h0056_7800_0000_0001, 64'h1256_7834_0000_0001};
        vecs[13] = '{2'b11, 6'd10, 64'h1111_2222_3333_4444, 64'h5,                  64'h0};
        vecs[14] = '{2'b10, 6'd9, 64'hFFFF_FFFF_8000_0000, 64'h0000_0020_0000_001F, 64'hFFFF_FFFF_0000_0001};

        // Reset state: a store sits at pc 0 but nothing may be driven while reset is high.
        begin_prog();
        imem[0] = enc_mem(SD, 5'd0, 16'hC002);
        repeat (3) @(negedge clk);
        $display("reset: pc=%h memEn=%b nicEn=%b", bus.pc, bus.memEn, bus.nicEn);
        chk("reset_pc",      64'(bus.pc), 64'd0);
        chk("reset_memEn",   64'(bus.memEn), 64'd0);
        chk("reset_nicEn",   64'(bus.nicEn), 64'd0);
        chk("reset_nicEnWr", 64'(bus.nicEnWr), 64'd0);
        chk("reset_addr",    64'(bus.addr), 64'd0);

        // ALU table
        for (int i = 0; i < 15; i++) begin
            run_alu(i, vecs[i].ww, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Randomized ALU against the reference model
        for (int i = 0; i < 24; i++) begin
            rww = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rfn = 6'($urandom_range(0, 63));
            else                           rfn = 6'($urandom_range(1, 9));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            run_alu(100 + i, rww, rfn, ra, rb, ref_alu(rww, rfn, ra, rb));
        end

        // Writes to r0 are discarded
        begin_prog();
        imem[0] = enc_mem(LD, 5'd1, 16'd1);
        imem[1] = enc_alu(5'd0, 5'd1, 5'd0, 2'b11, 6'd5);
        imem[2] = enc_mem(SD, 5'd0, 16'd3);
        poke(8'd1, 64'h0123_4567_89AB_CDEF);
        poke(8'd3, 64'hFFFF);
        release_reset();
        run_to_halt("r0_halt", 50);
        $display("r0 write: stored %h", dmem[3]);
        chk("r0_reads_zero", dmem[3], 64'h0);

        // Load/store: LD r3,5 then SD r3,6
        begin_prog();
        imem[0] = enc_mem(LD, 5'd3, 16'd5);
        imem[1] = enc_mem(SD, 5'd3, 16'd6);
        poke(8'd5, 64'hDEAD_BEEF_0000_1234);
        poke(8'd6, 64'h0);
        release_reset();
        chk("ld_memEn",    64'(bus.memEn), 64'd1);
        chk("ld_memWrEn",  64'(bus.memWrEn), 64'd0);
        chk("ld_memAddr",  64'(bus.memAddr), 64'd5);
        @(negedge clk);
        chk("load_pc",     64'(bus.pc), 64'd0);
        chk("load_memEn",  64'(bus.memEn), 64'd0);
        @(negedge clk);
        chk("sd_pc",       64'(bus.pc), 64'd4);
        chk("sd_memEn",    64'(bus.memEn), 64'd1);
        chk("sd_memWrEn",  64'(bus.memWrEn), 64'd1);
        chk("sd_memAddr",  64'(bus.memAddr), 64'd6);
        chk("sd_dataOut",  bus.dataOut, 64'hDEAD_BEEF_0000_1234);
        @(negedge clk);
        chk("halt_pc",     64'(bus.pc), 64'd8);
        chk("halt_memEn",  64'(bus.memEn), 64'd0);
        $display("ldsd: dmem[6]=%h", dmem[6]);
        chk("ldsd_dmem6",  dmem[6], 64'hDEAD_BEEF_0000_1234);

        // NIC store and load
        begin_prog();
        imem[0] = enc_mem(LD, 5'd3, 16'd5);
        imem[1] = enc_mem(SD, 5'd3, 16'hC002);
        imem[2] = enc_mem(LD, 5'd4, 16'hC001);
        imem[3] = enc_mem(SD, 5'd4, 16'd7);
        poke(8'd7, 64'h0);
        release_reset();
        @(negedge clk);
        @(negedge clk);
        chk("nsd_nicEn",   64'(bus.nicEn), 64'd1);
        chk("nsd_nicEnWr", 64'(bus.nicEnWr), 64'd1);
        chk("nsd_addr",    64'(bus.addr), 64'd2);
        chk("nsd_d_in",    bus.d_in, 64'hDEAD_BEEF_0000_1234);
        chk("nsd_memEn",   64'(bus.memEn), 64'd0);
        @(negedge clk);
        chk("nld_nicEn",   64'(bus.nicEn), 64'd1);
        chk("nld_nicEnWr", 64'(bus.nicEnWr), 64'd0);
        chk("nld_addr",    64'(bus.addr), 64'd1);
        chk("nld_memEn",   64'(bus.memEn), 64'd0);
        @(negedge clk);
        chk("nload_nicEn", 64'(bus.nicEn), 64'd0);
        run_to_halt("nic_halt", 50);
        $display("nic: nic_regs[2]=%h dmem[7]=%h", nic_regs[2], dmem[7]);
        chk("nic_reg2",    nic_regs[2], 64'hDEAD_BEEF_0000_1234);
        chk("nic_load",    dmem[7], 64'h55);

        // HALT holds pc with no enables
        pc_hold = bus.pc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_hold_pc", 64'(bus.pc), 64'(pc_hold));
            chk("halt_no_en",   64'({bus.memEn, bus.nicEn}), 64'd0);
        end
        $display("halt: pc held at %h", pc_hold);

        // Branches: BEZ r0 taken, BNEZ r0 falls through, self-branch loops
        begin_prog();
        imem[0] = enc_mem(BEZ,  5'd0, 16'h0010);
        imem[4] = enc_mem(BNEZ, 5'd0, 16'h0040);
        imem[5] = enc_mem(BEZ,  5'd0, 16'h0014);
        release_reset();
        chk("br_pc0", 64'(bus.pc), 64'h0);
        @(negedge clk);
        chk("bez_taken", 64'(bus.pc), 64'h10);
        @(negedge clk);
        chk("bnez_fall", 64'(bus.pc), 64'h14);
        @(negedge clk);
        chk("self_loop1", 64'(bus.pc), 64'h14);
        @(negedge clk);
        chk("self_loop2", 64'(bus.pc), 64'h14);
        $display("branch: pc=%h", bus.pc);

        // Reset asserted in the middle of a LOAD cycle
        begin_prog();
        imem[0] = enc_mem(NOP, 5'd0, 16'h0);
        imem[1] = enc_mem(LD,  5'd3, 16'd5);
        imem[2] = enc_mem(SD,  5'd3, 16'd6);
        poke(8'd6, 64'h0);
        release_reset();
        @(negedge clk);
        chk("mid_ld_memEn", 64'(bus.memEn), 64'd1);
        @(negedge clk);
        chk("mid_load_pc", 64'(bus.pc), 64'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_pc",    64'(bus.pc), 64'd0);
        chk("rst_async_memEn", 64'(bus.memEn), 64'd0);
        release_reset();
        chk("restart_pc", 64'(bus.pc), 64'd0);
        @(negedge clk);
        chk("restart_ld_pc",   64'(bus.pc), 64'd4);
        chk("restart_ld_addr", 64'(bus.memAddr), 64'd5);
        run_to_halt("restart_halt", 50);
        $display("reset mid-load: dmem[6]=%h", dmem[6]);
        chk("restart_result", dmem[6], 64'hDEAD_BEEF_0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
